// File: rtl/dff_sync_set_rst_pkg.sv
// Shared definitions for the sync-set/sync-reset register: legal width range and
// the per-edge action chosen from the control inputs.
package dff_sync_set_rst_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        LOAD_D      = 2'd0,
        FORCE_SET   = 2'd1,
        FORCE_RESET = 2'd2
    } action_e;

    // Reset outranks set, which outranks the data load.
    function automatic action_e edge_action(input logic reset, input logic set);
        if (!reset) begin
            return FORCE_RESET;
        end
        if (set) begin
            return FORCE_SET;
        end
        return LOAD_D;
    endfunction

endpackage

// File: rtl/dff_sync_set_rst_bit.sv
// Single-bit storage cell: synchronous active-low reset, synchronous active-high set.
module dff_sync_set_rst_bit
    import dff_sync_set_rst_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic set,
    input  logic d,
    output logic q
);

    always_ff @(posedge clock) begin
        case (edge_action(reset, set))
            FORCE_RESET: q <= 1'b0;
            FORCE_SET:   q <= 1'b1;
            default:     q <= d;
        endcase
    end

endmodule

// File: rtl/dff_sync_set_rst.sv
// WIDTH-bit register built from independent bit cells; qbar is derived from q
// combinationally so the two outputs can never disagree.
module dff_sync_set_rst
    import dff_sync_set_rst_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_sync_set_rst_bit u_bit (
            .clock (clock),
            .reset (reset),
            .set   (set),
            .d     (d[i]),
            .q     (q[i])
        );
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_dff_sync_set_rst.sv
// Directed bench for dff_sync_set_rst at WIDTH=8 and WIDTH=1 sharing clock and controls.
module tb_dff_sync_set_rst;

    logic       clock = 1'b0;
    logic       reset;
    logic       set;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qbar8;
    logic       d1;
    logic       q1;
    logic       qbar1;

    int  errors  = 0;
    int  checks  = 0;
    bit  started = 1'b0;
    time last_rise = 0;

    always #5 clock = ~clock;

    dff_sync_set_rst #(.WIDTH(8)) dut8 (
        .clock (clock),
        .reset (reset),
        .set   (set),
        .d     (d8),
        .q     (q8),
        .qbar  (qbar8)
    );

    dff_sync_set_rst #(.WIDTH(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .set   (set),
        .d     (d1),
        .q     (q1),
        .qbar  (qbar1)
    );

    always @(posedge clock) last_rise = $time;

    // Complement invariant, sampled mid-cycle.
    always @(negedge clock) begin
        if (started) begin
            checks++;
            if (qbar8 !== ~q8 || qbar1 !== ~q1) begin
                $display("FAIL qbar_invariant: q8=%h qbar8=%h q1=%b qbar1=%b", q8, qbar8, q1, qbar1);
                errors++;
            end
        end
    end

    // Outputs may only move in the time step of a rising edge.
    always @(q8 or q1) begin
        if (started) begin
            checks++;
            if ($time != last_rise) begin
                $display("FAIL q_change_time: changed at %0t, last rising edge %0t", $time, last_rise);
                errors++;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; set = 1'b0; d8 = 8'hFF; d1 = 1'b1;
        step();
        started = 1'b1;
        checks++;
        if (q8 !== 8'h00 || qbar8 !== 8'hFF) begin
            $display("FAIL reset_w8: q=%h qbar=%h expected q=00 qbar=ff", q8, qbar8);
            errors++;
        end
        checks++;
        if (q1 !== 1'b0 || qbar1 !== 1'b1) begin
            $display("FAIL reset_w1: q=%b qbar=%b expected q=0 qbar=1", q1, qbar1);
            errors++;
        end
    endtask

    task automatic test_reset_beats_set();
        reset = 1'b0; set = 1'b1; d8 = 8'hFF; d1 = 1'b1;
        step();
        checks++;
        if (q8 !== 8'h00 || q1 !== 1'b0) begin
            $display("FAIL reset_beats_set: q8=%h q1=%b expected 00/0", q8, q1);
            errors++;
        end
    endtask

    task automatic test_data_load();
        reset = 1'b1; set = 1'b0; d1 = 1'b1; d8 = 8'h3C;
        step();
        checks++;
        if (q1 !== 1'b1 || qbar1 !== 1'b0 || q8 !== 8'h3C) begin
            $display("FAIL load_one: q1=%b qbar1=%b q8=%h expected 1/0/3c", q1, qbar1, q8);
            errors++;
        end
        d1 = 1'b0; d8 = 8'hC3;
        step();
        checks++;
        if (q1 !== 1'b0 || qbar1 !== 1'b1 || q8 !== 8'hC3) begin
            $display("FAIL load_zero: q1=%b qbar1=%b q8=%h expected 0/1/c3", q1, qbar1, q8);
            errors++;
        end
    endtask

    task automatic test_set();
        reset = 1'b1; set = 1'b1; d1 = 1'b0; d8 = 8'h00;
        step();
        checks++;
        if (q8 !== 8'hFF || qbar8 !== 8'h00 || q1 !== 1'b1 || qbar1 !== 1'b0) begin
            $display("FAIL set: q8=%h qbar8=%h q1=%b qbar1=%b expected ff/00/1/0", q8, qbar8, q1, qbar1);
            errors++;
        end
        d8 = 8'h5A;
        step();
        checks++;
        if (q8 !== 8'hFF || q1 !== 1'b1) begin
            $display("FAIL set_hold: q8=%h q1=%b expected ff/1", q8, q1);
            errors++;
        end
    endtask

    task automatic test_sync_glitch();
        reset = 1'b1; set = 1'b0; d8 = 8'h69; d1 = 1'b1;
        step();
        checks++;
        if (q8 !== 8'h69) begin
            $display("FAIL glitch_setup: q8=%h expected 69", q8);
            errors++;
        end

        @(negedge clock); reset = 1'b0; #1;
        checks++;
        if (q8 !== 8'h69 || q1 !== 1'b1) begin
            $display("FAIL reset_glitch_async: q8=%h q1=%b expected 69/1", q8, q1);
            errors++;
        end
        #2 reset = 1'b1;
        step();
        checks++;
        if (q8 !== 8'h69 || q1 !== 1'b1) begin
            $display("FAIL reset_glitch_edge: q8=%h q1=%b expected 69/1", q8, q1);
            errors++;
        end

        @(negedge clock); set = 1'b1; #1;
        checks++;
        if (q8 !== 8'h69) begin
            $display("FAIL set_glitch_async: q8=%h expected 69", q8);
            errors++;
        end
        #2 set = 1'b0;
        step();
        checks++;
        if (q8 !== 8'h69) begin
            $display("FAIL set_glitch_edge: q8=%h expected 69", q8);
            errors++;
        end

        @(negedge clock); d8 = 8'h00; d1 = 1'b0; #1;
        checks++;
        if (q8 !== 8'h69 || q1 !== 1'b1) begin
            $display("FAIL d_glitch_async: q8=%h q1=%b expected 69/1", q8, q1);
            errors++;
        end
        #2 begin d8 = 8'h69; d1 = 1'b1; end
        step();
        checks++;
        if (q8 !== 8'h69 || q1 !== 1'b1) begin
            $display("FAIL d_glitch_edge: q8=%h q1=%b expected 69/1", q8, q1);
            errors++;
        end
    endtask

    task automatic test_width();
        reset = 1'b1; set = 1'b0; d8 = 8'hA5; d1 = 1'b0;
        step();
        checks++;
        if (q8 !== 8'hA5 || qbar8 !== 8'h5A) begin
            $display("FAIL width_load: q=%h qbar=%h expected a5/5a", q8, qbar8);
            errors++;
        end
        set = 1'b1;
        step();
        checks++;
        if (q8 !== 8'hFF || qbar8 !== 8'h00) begin
            $display("FAIL width_set: q=%h qbar=%h expected ff/00", q8, qbar8);
            errors++;
        end
        reset = 1'b0;
        step();
        checks++;
        if (q8 !== 8'h00 || qbar8 !== 8'hFF) begin
            $display("FAIL width_reset: q=%h qbar=%h expected 00/ff", q8, qbar8);
            errors++;
        end
    endtask

    // Columns: reset, set, d8, expected q8, expected q1 (d1 follows d8[0]).
    logic       v_rst [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       v_set [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] v_d   [8] = '{8'h12, 8'h35, 8'h34, 8'h00, 8'hAB, 8'hAB, 8'hFF, 8'h81};
    logic [7:0] v_q8  [8] = '{8'h12, 8'h35, 8'hFF, 8'h00, 8'h00, 8'hAB, 8'h00, 8'h81};
    logic       v_q1  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            reset = v_rst[i]; set = v_set[i]; d8 = v_d[i]; d1 = v_d[i][0];
            step();
            checks++;
            if (q8 !== v_q8[i] || q1 !== v_q1[i]) begin
                $display("FAIL back_to_back[%0d]: q8=%h q1=%b expected %h/%b", i, q8, q1, v_q8[i], v_q1[i]);
                errors++;
            end
        end
    endtask

    initial begin
        reset = 1'b0; set = 1'b0; d8 = 8'h00; d1 = 1'b0;
        test_reset();
        test_reset_beats_set();
        test_data_load();
        test_set();
        test_sync_glitch();
        test_width();
        test_back_to_back();
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within time budget");
        $fatal(1, "timeout");
    end

endmodule
